// File: rtl/float_div_round_normalize_pkg.sv
// +--------------------------------------------------------------------------+
// | float_div_round_normalize_pkg                                            |
// | Shared float widths, stage-1 to stage-2 pipeline record, exponent helper |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package float_div_round_normalize_pkg;

  localparam int PKG_EXPONENT_SIZE = 8;
  localparam int PKG_MANTISSA_SIZE = 23;

  function automatic bit widths_ok(input int float_size, input int exponent_size,
                                   input int mantissa_size);
    return float_size == 1 + exponent_size + mantissa_size;
  endfunction

  // Widened signed exponent holding the value 2^E - 1 (inf/NaN encoding).
  function automatic logic signed [PKG_EXPONENT_SIZE+1:0] exp_all_ones();
    return {2'b00, {PKG_EXPONENT_SIZE{1'b1}}};
  endfunction

  typedef struct packed {
    logic                                sign;
    logic signed [PKG_EXPONENT_SIZE+1:0] exponent;
    logic [PKG_MANTISSA_SIZE-1:0]        mantissa;
    logic                                guard_bit;
    logic                                round_bit;
    logic                                sticky_bit;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/float_div_round_normalize_round.sv
// +--------------------------------------------------------------------------+
// | round_nearest_even                                                       |
// | Combinational round-to-nearest-even of a fraction using G/R/S bits       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module round_nearest_even #(
  parameter int MANTISSA_SIZE = 23
) (
  input  logic [MANTISSA_SIZE-1:0] mantissa,
  input  logic                     guard_bit,
  input  logic                     round_bit,
  input  logic                     sticky_bit,
  output logic [MANTISSA_SIZE-1:0] rounded,
  output logic                     carry,
  output logic                     inexact
);

  logic w_increment;

  // Ties (G set, nothing below) round toward an even LSB.
  assign w_increment       = guard_bit & (round_bit | sticky_bit | mantissa[0]);
  assign {carry, rounded}  = {1'b0, mantissa} + {{MANTISSA_SIZE{1'b0}}, w_increment};
  assign inexact           = guard_bit | round_bit | sticky_bit;

endmodule

`default_nettype wire

// File: rtl/float_div_round_normalize.sv
// +--------------------------------------------------------------------------+
// | float_div_round_normalize                                                |
// | Two-stage normalise / RNE round of divider quotient with valid/ready     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module float_div_round_normalize
  import float_div_round_normalize_pkg::*;
#(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXPONENT_SIZE+1:0]   in_exponent,
  input  logic [MANTISSA_SIZE+3:0]   in_quotient,
  input  logic                       in_sticky,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLOAT_SIZE-1:0]      out,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       inexact
);

  if (!widths_ok(FLOAT_SIZE, EXPONENT_SIZE, MANTISSA_SIZE) ||
      EXPONENT_SIZE != PKG_EXPONENT_SIZE || MANTISSA_SIZE != PKG_MANTISSA_SIZE) begin : g_width_check
    $error("float_div_round_normalize: inconsistent float widths");
  end

  stage_t                          r_s1;
  stage_t                          w_s1_next;
  logic                            r_s1_valid;
  logic                            w_adv1;
  logic                            w_adv2;
  logic [MANTISSA_SIZE+2:0]        w_frac;
  logic [MANTISSA_SIZE-1:0]        w_man_rounded;
  logic                            w_carry;
  logic                            w_inexact;
  logic signed [EXPONENT_SIZE+1:0] w_exp_post;
  logic                            w_ovf;
  logic                            w_udf;
  logic [FLOAT_SIZE-1:0]           w_result;

  assign w_adv2   = ~out_valid | out_ready;
  assign w_adv1   = ~r_s1_valid | w_adv2;
  assign in_ready = w_adv1;

  // Stage 1: a quotient below 1.0 gains one bit of precision by shifting left.
  always_comb begin
    w_frac                = in_quotient[MANTISSA_SIZE+3] ? in_quotient[MANTISSA_SIZE+2:0]
                                                         : {in_quotient[MANTISSA_SIZE+1:0], 1'b0};
    w_s1_next.sign        = in_sign;
    w_s1_next.exponent    = in_quotient[MANTISSA_SIZE+3]
                            ? in_exponent
                            : in_exponent - {{(EXPONENT_SIZE+1){1'b0}}, 1'b1};
    w_s1_next.mantissa    = w_frac[MANTISSA_SIZE+2:3];
    w_s1_next.guard_bit   = w_frac[2];
    w_s1_next.round_bit   = w_frac[1];
    w_s1_next.sticky_bit  = w_frac[0] | in_sticky;
  end

  round_nearest_even #(
    .MANTISSA_SIZE(MANTISSA_SIZE)
  ) u_round (
    .mantissa  (r_s1.mantissa),
    .guard_bit (r_s1.guard_bit),
    .round_bit (r_s1.round_bit),
    .sticky_bit(r_s1.sticky_bit),
    .rounded   (w_man_rounded),
    .carry     (w_carry),
    .inexact   (w_inexact)
  );

  // Stage 2: range checks use the exponent after any rounding carry.
  assign w_exp_post = r_s1.exponent + {{(EXPONENT_SIZE+1){1'b0}}, w_carry};
  assign w_ovf      = w_exp_post >= exp_all_ones();
  assign w_udf      = w_exp_post[EXPONENT_SIZE+1] | (w_exp_post == '0);

  always_comb begin
    w_result = {r_s1.sign, w_exp_post[EXPONENT_SIZE-1:0], w_man_rounded};
    if (w_ovf) begin
      w_result = {r_s1.sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
    end else if (w_udf) begin
      w_result = {r_s1.sign, {(FLOAT_SIZE-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
      out_valid  <= 1'b0;
      out        <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      inexact    <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1 <= w_s1_next;
        end
      end
      if (w_adv2) begin
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          out       <= w_result;
          overflow  <= w_ovf;
          underflow <= w_udf;
          inexact   <= w_inexact | w_ovf | w_udf;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_float_div_round_normalize.sv
// +--------------------------------------------------------------------------+
// | tb_float_div_round_normalize                                             |
// | Table-driven scoreboard bench for the divider normalise/round stage      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_float_div_round_normalize;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] q;
    logic        sticky;
    logic [31:0] out;
    logic        ov;
    logic        uf;
    logic        inx;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        ov;
    logic        uf;
    logic        inx;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exponent = '0;
  logic [26:0] in_quotient = '0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        overflow, underflow, inexact;

  int   checks = 0;
  int   fails  = 0;
  res_t sb[$];
  vec_t vecs[15];

  logic        held_v = 1'b0;
  logic [31:0] held_out;
  logic [2:0]  held_flags;
  res_t        popped;

  always #5 clk = ~clk;

  float_div_round_normalize dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exponent(in_exponent),
    .in_quotient(in_quotient),
    .in_sticky  (in_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .overflow   (overflow),
    .underflow  (underflow),
    .inexact    (inexact)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Output monitor: scoreboard pop on transfer, hold check while stalled.
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_out", out, held_out);
        chk("hold_flags", {29'b0, overflow, underflow, inexact}, {29'b0, held_flags});
      end
      if (out_valid && out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got %h expected none", out);
        end else begin
          popped = sb.pop_front();
          chk("result", out, popped.out);
          chk("flags", {29'b0, overflow, underflow, inexact},
              {29'b0, popped.ov, popped.uf, popped.inx});
        end
      end else if (out_valid) begin
        held_v     = 1'b1;
        held_out   = out;
        held_flags = {overflow, underflow, inexact};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic apply(input vec_t v);
    in_valid    = 1'b1;
    in_sign     = v.sign;
    in_exponent = v.exp;
    in_quotient = v.q;
    in_sticky   = v.sticky;
  endtask

  task automatic push_exp(input vec_t v);
    res_t r;
    r.out = v.out; r.ov = v.ov; r.uf = v.uf; r.inx = v.inx;
    sb.push_back(r);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int n = 0;
    apply(v);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      push_exp(v);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Input known to be accepted on the next edge; out_valid must rise two edges later.
  task automatic latency_check(input vec_t v);
    apply(v);
    push_exp(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("latency_1", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("latency_2", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    //          sign exp     q             stk  out           ov  uf  inx
    vecs[0]  = '{0, 10'd127, 27'h6000000, 0, 32'h3FC00000, 0, 0, 0};  // 1.5 exact
    vecs[1]  = '{0, 10'd128, 27'h3000000, 0, 32'h3FC00000, 0, 0, 0};  // 0.75 normalised
    vecs[2]  = '{0, 10'd127, 27'h7FFFFFC, 0, 32'h40000000, 0, 0, 1};  // carry-out
    vecs[3]  = '{0, 10'd127, 27'h4000004, 0, 32'h3F800000, 0, 0, 1};  // tie, even LSB
    vecs[4]  = '{0, 10'd127, 27'h400000C, 0, 32'h3F800002, 0, 0, 1};  // tie, odd LSB
    vecs[5]  = '{0, 10'd255, 27'h4000000, 0, 32'h7F800000, 1, 0, 1};  // overflow
    vecs[6]  = '{1, 10'd0,   27'h4000000, 0, 32'h80000000, 0, 1, 1};  // underflow at 0
    vecs[7]  = '{0, 10'h3FD, 27'h4000000, 0, 32'h00000000, 0, 1, 1};  // exponent -3
    vecs[8]  = '{0, 10'd127, 27'h4000000, 1, 32'h3F800000, 0, 0, 1};  // sticky only
    vecs[9]  = '{0, 10'd127, 27'h4000006, 0, 32'h3F800001, 0, 0, 1};  // above half
    vecs[10] = '{0, 10'd254, 27'h7FFFFFC, 0, 32'h7F800000, 1, 0, 1};  // carry into inf
    vecs[11] = '{0, 10'd1,   27'h3000000, 0, 32'h00000000, 0, 1, 1};  // shift into 0
    vecs[12] = '{1, 10'd254, 27'h6000000, 0, 32'hFF400000, 0, 0, 0};  // largest finite
    vecs[13] = '{0, 10'd1,   27'h4000000, 0, 32'h00800000, 0, 0, 0};  // smallest normal
    vecs[14] = '{0, 10'd127, 27'h2000001, 0, 32'h3F000000, 0, 0, 1};  // shifted, R set

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out", out, 32'd0);
    chk("reset_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    latency_check(vecs[0]);
    drain();

    for (int i = 0; i < 15; i++) begin
      send(vecs[i]);
    end
    drain();

    // Back-pressure: out_ready low for four cycles while five beats stream in.
    fork
      begin
        for (int i = 0; i < 5; i++) send(vecs[i + 2]);
      end
      begin
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_accepted", sb.size(), 32'd2);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight discards both.
    out_ready = 1'b0;
    send(vecs[2]);
    send(vecs[5]);
    #2 reset = 1'b1;
    #1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    latency_check(vecs[3]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/float_div_round_normalize.md
# float_div_round_normalize

Two-stage pipelined normalise-and-round stage that sits directly downstream of the floating-point divider's sign/exponent/quotient datapath. It accepts a raw quotient in [0.5, 2) with a widened biased exponent and extra precision bits. It produces a packed IEEE-style float rounded to nearest-even, with overflow, underflow and inexact flags. A valid/ready handshake with full back-pressure lets it sit between a multicycle divider and any result consumer.

## Interface
- FLOAT_SIZE, 32, total float width; must equal 1 + EXPONENT_SIZE + MANTISSA_SIZE
- EXPONENT_SIZE, 8, exponent field width
- MANTISSA_SIZE, 23, stored fraction width (hidden bit excluded)

- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  input beat present
- in_ready  output  1  stage can accept input this cycle
- in_sign  input  1  result sign
- in_exponent  input  EXPONENT_SIZE+2  biased exponent, two's complement, unbiased range not pre-checked
- in_quotient  input  MANTISSA_SIZE+4  fixed point: bit [MANTISSA_SIZE+3] is the integer bit, remaining MANTISSA_SIZE+3 bits are fraction; value in [0.5, 2)
- in_sticky  input  1  OR of all quotient bits/remainder below in_quotient LSB
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- out  output  FLOAT_SIZE  {sign, exponent, mantissa}
- overflow, underflow, inexact  output  1 each  flags qualified by out_valid

## Operation
- Stage 1 (normalise): if in_quotient MSB = 0, shift left by 1 and exponent − 1; else unchanged. From the normalised value, take 1.M (MANTISSA_SIZE fraction bits), guard G, and round R. Fold any remaining lower bits into sticky S together with in_sticky.
- Stage 2 (round, RNE): increment when G & (R | S | LSB). On mantissa carry-out, mantissa becomes 0 and exponent + 1. inexact = G | R | S before the overflow/underflow override.
- Exponent checks on the post-round exponent, signed EXPONENT_SIZE+2 arithmetic:
  - ≥ 2^EXPONENT_SIZE − 1: out = {sign, all-ones, 0} (±inf); overflow = 1, inexact = 1.
  - ≤ 0: out = {sign, 0, 0} (±0, flush, no subnormals); underflow = 1, inexact = 1.
  - Otherwise flags are 0 except inexact.
- Overflow and underflow are mutually exclusive.
- Sign passes through unchanged in every case.

## Timing
- Latency 2 cycles: an input accepted on edge n appears on out at edge n+2 when not stalled. Throughput 1 beat/cycle.
- Transfer occurs when valid & ready are both high on a rising edge.
- adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1. in_ready is combinational from out_ready; no combinational path from in_valid to out_valid.
- While out_valid = 1 and out_ready = 0, out and all flags hold stable.
- Stalled with both stages full: in_ready = 0 and no beat is lost or duplicated. Stage 1 refills in the same cycle that stage 2 drains.
- Reset values: s1_valid = s2_valid = 0; out_valid = 0; out = 0; overflow = underflow = inexact = 0. in_ready = 1 after reset.
- Reset asserted mid-operation discards in-flight beats immediately, asynchronously. The first post-reset accept behaves as from empty.

## Structure
- Shared float package holds:
  - the width-relation check (FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE)
  - the stage-1 → stage-2 pipeline struct {sign, exponent, mantissa, G, R, S}
  - the all-ones exponent constant helper
- One combinational sub-module, round_nearest_even: inputs mantissa, G, R, S; outputs rounded mantissa, carry, inexact. The multiplier datapath reuses it.

## Test plan
All cases use float32 parameters.
- q = 1.5 exact (0xC00000 << 3), exp 127, sticky 0 → out 0x3FC00000, all flags 0, at exactly 2 cycles.
- q = 0.75 (MSB 0), exp 128 → normalised to 1.5, out 0x3FC00000, inexact 0.
- q = 1.(23 ones), G = 1, exp 127 → carry-out, out 0x40000000, inexact 1.
- Tie: LSB 0, G = 1, R = 0, S = 0 → truncated mantissa unchanged, inexact 1. Same with LSB 1 → mantissa + 1.
- Exp 255, q = 1.0 → 0x7F800000, overflow 1. Exp 0, sign 1 → 0x80000000, underflow 1. Exp −3 → underflow 1.
- Back-pressure:
  - Stream 5 beats with out_ready low for cycles 2–5: in_ready drops after 2 accepted beats; all 5 results emerge in order, stable while stalled.
  - Pulse reset with 2 beats in flight: out_valid = 0 at once; the next input yields a correct result 2 cycles later.
